nes_bus_responder: RTL

Memory-side responder for the 6502 `CPU` bus: it answers `Addr_bus`/`R_nW` with `Data_bus_in` and commits CPU writes. It provides 2 KB work RAM mirrored like the NES, fixed interrupt/reset vectors, and an optional programmable interval timer that drives the CPU's active-low `irq`/`nmi` inputs. It sits directly opposite `CPU` and replaces bench-side behavioural memory in system builds.

---
 rtl/nes_bus_responder.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/nes_bus_responder.sv
// 6502 bus responder: 2 KB mirrored work RAM, fixed vectors, optional interval timer.
// Define NES_BUS_TIMER_EN to build the timer at $4020-$4023 and its irq/nmi outputs.
module nes_bus_responder #(
  parameter logic [15:0] NMI_VEC = 16'h2000,
  parameter logic [15:0] RST_VEC = 16'h0000,
  parameter logic [15:0] IRQ_VEC = 16'h2000
) (
  input  logic        clk_ph1,
  input  logic        rst,
  input  logic [15:0] Addr_bus,
  input  logic [7:0]  Data_bus_out,
  input  logic        R_nW,
  output logic [7:0]  Data_bus_in,
  output logic        irq,
  output logic        nmi
);

  logic       ram_sel;
  logic       tmr_sel;
  logic       vec_sel;
  logic       wr_en;
  logic [7:0] ram_q [2048];
  logic [7:0] ram_rdata;
  logic [7:0] vec_rdata;
  logic [7:0] tmr_rdata;

  always_comb begin
    ram_sel = (Addr_bus[15:13] == 3'b000);
    tmr_sel = (Addr_bus[15:2] == 14'h1008);
    vec_sel = (Addr_bus[15:3] == 13'h1FFF) && (Addr_bus[2:1] != 2'b00);
    wr_en   = ~R_nW;
  end

  // RAM has no reset: contents are undefined until written.
  always_ff @(posedge clk_ph1) begin
    if (wr_en && ram_sel) ram_q[Addr_bus[10:0]] <= Data_bus_out;
  end

  assign ram_rdata = ram_q[Addr_bus[10:0]];

  always_comb begin
    vec_rdata = 8'h00;
    case (Addr_bus[2:0])
      3'd2:    vec_rdata = NMI_VEC[7:0];
      3'd3:    vec_rdata = NMI_VEC[15:8];
      3'd4:    vec_rdata = RST_VEC[7:0];
      3'd5:    vec_rdata = RST_VEC[15:8];
      3'd6:    vec_rdata = IRQ_VEC[7:0];
      3'd7:    vec_rdata = IRQ_VEC[15:8];
      default: vec_rdata = 8'h00;
    endcase
  end

  always_comb begin
    Data_bus_in = 8'h00;
    if (ram_sel)      Data_bus_in = ram_rdata;
    else if (vec_sel) Data_bus_in = vec_rdata;
    else if (tmr_sel) Data_bus_in = tmr_rdata;
  end

`ifdef NES_BUS_TIMER_EN
  // state | meaning
  // IDLE  | EN=0, counter holds
  // RUN   | EN=1, counter decrements, expires at zero
  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q, state_d;
  logic [15:0] rld_q, rld_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  ctrl_q, ctrl_d;  // {AUTO, NMI_SEL, INT_EN}; EN is the FSM state
  logic        pend_q, pend_d;
  logic        expire;

  assign expire = (state_q == RUN) && (cnt_q == 16'h0000);

  always_comb begin
    state_d = state_q;
    rld_d   = rld_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    pend_d  = pend_q;
    if (state_q == RUN) begin
      if (expire) begin
        if (ctrl_q[2]) cnt_d = rld_q;
        else           state_d = IDLE;
      end else begin
        cnt_d = cnt_q - 16'd1;
      end
    end
    if (wr_en && tmr_sel) begin
      case (Addr_bus[1:0])
        2'd0: rld_d[7:0]  = Data_bus_out;
        2'd1: rld_d[15:8] = Data_bus_out;
        2'd2: begin
          // A CTRL write overrides whatever the tick decided this edge.
          ctrl_d = Data_bus_out[3:1];
          if (Data_bus_out[0]) begin
            state_d = RUN;
            cnt_d   = rld_q;
          end else begin
            state_d = IDLE;
            cnt_d   = cnt_q;
          end
        end
        default: if (Data_bus_out[0]) pend_d = 1'b0;
      endcase
    end
    if (expire) pend_d = 1'b1;
  end

  always_ff @(posedge clk_ph1) begin
    if (!rst) begin
      state_q <= IDLE;
      rld_q   <= 16'h0000;
      cnt_q   <= 16'h0000;
      ctrl_q  <= 3'b000;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rld_q   <= rld_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    tmr_rdata = 8'h00;
    case (Addr_bus[1:0])
      2'd0:    tmr_rdata = cnt_q[7:0];
      2'd1:    tmr_rdata = cnt_q[15:8];
      2'd2:    tmr_rdata = {4'h0, ctrl_q, (state_q == RUN)};
      default: tmr_rdata = {7'h00, pend_q};
    endcase
  end

  assign irq = ~(pend_q & ctrl_q[0] & ~ctrl_q[1]);
  assign nmi = ~(pend_q & ctrl_q[0] & ctrl_q[1]);
`else
  assign tmr_rdata = 8'h00;
  assign irq       = 1'b1;
  assign nmi       = 1'b1;
`endif

endmodule
